// File: rtl/matrix_fb_responder.sv
// Wishbone classic responder: 2-page RGB565 framebuffer, double-buffered frame pointer
// and a registered pixel read port for the LED matrix scanner.
module matrix_fb_responder #(
    parameter int unsigned              ADDRESS_WIDTH = 16,
    parameter int unsigned              DATA_WIDTH    = 8,
    parameter int unsigned              DATA_BYTES    = 1,
    parameter logic [ADDRESS_WIDTH-1:0] FB_BASE       = 16'h0000,
    parameter logic [ADDRESS_WIDTH-1:0] REG_BASE      = 16'h1000,
    parameter int unsigned              WAIT_STATES   = 0
) (
    input  logic                     clk_i,
    input  logic                     rst_i,
    input  logic [ADDRESS_WIDTH-1:0] adr_i,
    input  logic [DATA_WIDTH-1:0]    dat_i,
    output logic [DATA_WIDTH-1:0]    dat_o,
    input  logic                     we_i,
    input  logic [DATA_BYTES-1:0]    sel_i,
    input  logic                     stb_i,
    input  logic                     cyc_i,
    output logic                     ack_o,
    input  logic [2:0]               cti_i,
    input  logic [8:0]               pix_addr_i,
    output logic [15:0]              pix_data_o,
    input  logic                     frame_sync_i,
    output logic [15:0]              active_ptr_o,
    output logic                     ptr_pending_o
);

    localparam int unsigned FB_BYTES  = 2048;
    localparam int unsigned REG_BYTES = 4;
    localparam int unsigned WORDS     = 1024;
    localparam int unsigned WORD_W    = 10;
    localparam int unsigned CNT_W     = 4;
    localparam int unsigned PTR_W     = 16;
    localparam int unsigned PIX_W     = 16;

    typedef enum logic [1:0] {
        ST_IDLE = 2'd0,
        ST_WAIT = 2'd1,
        ST_ACK  = 2'd2
    } state_t;

    state_t                   state_q, state_d;
    logic [CNT_W-1:0]         cnt_q, cnt_d;

    logic [ADDRESS_WIDTH-1:0] fb_off_c, reg_off_c;
    logic                     fb_hit_c, reg_hit_c, req_c, enter_ack_c;
    logic [WORD_W-1:0]        fb_word_c, pix_word_c;
    logic [PTR_W-1:0]         ptr_off_c;
    logic [DATA_WIDTH-1:0]    reg_rd_c;
    logic                     wr_c, fb_wr_c, reg_wr_c;

    logic                     ack_q;
    logic [DATA_WIDTH-1:0]    dat_q;
    logic [PIX_W-1:0]         pix_q;
    logic [DATA_WIDTH-1:0]    shadow_q;
    logic [PTR_W-1:0]         pend_q, act_q;
    logic                     pending_q;

    // Beat captured on entry to ACK; the write strobe uses it during ACK.
    logic                     acc_fb_q, acc_reg_q, acc_lane_q, acc_we_q, acc_sel_q;
    logic [WORD_W-1:0]        acc_word_q;
    logic [1:0]               acc_roff_q;
    logic [DATA_WIDTH-1:0]    acc_dat_q;

    logic [DATA_WIDTH-1:0]    fb_hi [WORDS];
    logic [DATA_WIDTH-1:0]    fb_lo [WORDS];

    logic                     unused_c;

    // Address decode; unsigned wrap below a base yields a large offset, i.e. a miss.
    assign fb_off_c    = adr_i - FB_BASE;
    assign reg_off_c   = adr_i - REG_BASE;
    assign fb_hit_c    = fb_off_c < ADDRESS_WIDTH'(FB_BYTES);
    assign reg_hit_c   = reg_off_c < ADDRESS_WIDTH'(REG_BYTES);
    assign req_c       = cyc_i & stb_i & (fb_hit_c | reg_hit_c);
    assign fb_word_c   = fb_off_c[WORD_W:1];
    assign enter_ack_c = (state_d == ST_ACK);

    assign ptr_off_c   = act_q - PTR_W'(FB_BASE);
    assign pix_word_c  = ptr_off_c[WORD_W:1] + WORD_W'(pix_addr_i);

    assign wr_c        = (state_q == ST_ACK) & acc_we_q & acc_sel_q;
    assign fb_wr_c     = wr_c & acc_fb_q;
    assign reg_wr_c    = wr_c & acc_reg_q;

    assign unused_c    = ^{cti_i, ptr_off_c[PTR_W-1:WORD_W+1], ptr_off_c[0]};

    always_comb begin
        reg_rd_c = '0;
        unique case (reg_off_c[1:0])
            2'd0:    reg_rd_c = shadow_q;
            2'd1:    reg_rd_c = pend_q[DATA_WIDTH-1:0];
            2'd2:    reg_rd_c = DATA_WIDTH'({act_q[10], pending_q});
            default: reg_rd_c = '0;
        endcase
    end

    // Bus FSM next state.
    always_comb begin
        state_d = state_q;
        cnt_d   = cnt_q;
        unique case (state_q)
            ST_IDLE: begin
                if (req_c) begin
                    if (WAIT_STATES == 0) begin
                        state_d = ST_ACK;
                    end else begin
                        state_d = ST_WAIT;
                        cnt_d   = CNT_W'(WAIT_STATES);
                    end
                end
            end
            ST_WAIT: begin
                if (!(cyc_i && stb_i)) begin
                    state_d = ST_IDLE;
                end else begin
                    cnt_d = cnt_q - CNT_W'(1);
                    if (cnt_q == CNT_W'(1)) begin
                        state_d = ST_ACK;
                    end
                end
            end
            ST_ACK:  state_d = ST_IDLE;
            default: state_d = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk_i) begin
        if (!rst_i) begin
            state_q    <= ST_IDLE;
            cnt_q      <= '0;
            ack_q      <= 1'b0;
            dat_q      <= '0;
            pix_q      <= '0;
            shadow_q   <= '0;
            pend_q     <= PTR_W'(FB_BASE);
            act_q      <= PTR_W'(FB_BASE);
            pending_q  <= 1'b0;
            acc_fb_q   <= 1'b0;
            acc_reg_q  <= 1'b0;
            acc_lane_q <= 1'b0;
            acc_we_q   <= 1'b0;
            acc_sel_q  <= 1'b0;
            acc_word_q <= '0;
            acc_roff_q <= '0;
            acc_dat_q  <= '0;
        end else begin
            state_q <= state_d;
            cnt_q   <= cnt_d;
            ack_q   <= enter_ack_c;
            pix_q   <= {fb_hi[pix_word_c], fb_lo[pix_word_c]};

            if (enter_ack_c && !we_i) begin
                if (fb_hit_c) begin
                    dat_q <= fb_off_c[0] ? fb_lo[fb_word_c] : fb_hi[fb_word_c];
                end else begin
                    dat_q <= reg_rd_c;
                end
            end else begin
                dat_q <= '0;
            end

            if (enter_ack_c) begin
                acc_fb_q   <= fb_hit_c;
                acc_reg_q  <= reg_hit_c;
                acc_lane_q <= fb_off_c[0];
                acc_we_q   <= we_i;
                acc_sel_q  <= sel_i[0];
                acc_word_q <= fb_word_c;
                acc_roff_q <= reg_off_c[1:0];
                acc_dat_q  <= dat_i;
            end

            // Flip uses the pending state from before any same-cycle commit.
            if (frame_sync_i && pending_q) begin
                act_q     <= pend_q;
                pending_q <= 1'b0;
            end

            if (reg_wr_c) begin
                unique case (acc_roff_q)
                    2'd0: shadow_q <= acc_dat_q;
                    2'd1: begin
                        pend_q    <= {shadow_q, acc_dat_q};
                        pending_q <= 1'b1;
                    end
                    default: ;
                endcase
            end
        end
    end

    // Byte-lane RAMs; contents survive reset, a reset during ACK suppresses the write.
    always_ff @(posedge clk_i) begin
        if (rst_i && fb_wr_c) begin
            if (acc_lane_q) begin
                fb_lo[acc_word_q] <= acc_dat_q;
            end else begin
                fb_hi[acc_word_q] <= acc_dat_q;
            end
        end
    end

    assign ack_o         = ack_q;
    assign dat_o         = dat_q;
    assign pix_data_o    = pix_q;
    assign active_ptr_o  = act_q;
    assign ptr_pending_o = pending_q;

endmodule

// File: tb/tb_matrix_fb_responder.sv
// Bench for matrix_fb_responder: two instances (0 and 3 wait states) checked against
// a word-array model of the framebuffer and pointer registers.
module tb_matrix_fb_responder;

    localparam logic [15:0] FB     = 16'h0000;
    localparam logic [15:0] RG     = 16'h1000;
    localparam int          BUDGET = 30;

    logic clk = 1'b0;
    always #5 clk = ~clk;

    logic        rst_n;
    logic [15:0] adr;
    logic [7:0]  dat;
    logic        we, sel, fs;
    logic [2:0]  cti;
    logic [8:0]  pix;
    logic        cyc [2];
    logic        stb [2];
    logic        ack [2];
    logic [7:0]  dato [2];
    logic [15:0] pixd [2];
    logic [15:0] actp [2];
    logic        pnd [2];

    int total = 0;
    int bad   = 0;

    matrix_fb_responder #(.WAIT_STATES(0)) u_dut0 (
        .clk_i(clk), .rst_i(rst_n), .adr_i(adr), .dat_i(dat), .dat_o(dato[0]),
        .we_i(we), .sel_i(sel), .stb_i(stb[0]), .cyc_i(cyc[0]), .ack_o(ack[0]),
        .cti_i(cti), .pix_addr_i(pix), .pix_data_o(pixd[0]), .frame_sync_i(fs),
        .active_ptr_o(actp[0]), .ptr_pending_o(pnd[0])
    );

    matrix_fb_responder #(.WAIT_STATES(3)) u_dut3 (
        .clk_i(clk), .rst_i(rst_n), .adr_i(adr), .dat_i(dat), .dat_o(dato[1]),
        .we_i(we), .sel_i(sel), .stb_i(stb[1]), .cyc_i(cyc[1]), .ack_o(ack[1]),
        .cti_i(cti), .pix_addr_i(pix), .pix_data_o(pixd[1]), .frame_sync_i(fs),
        .active_ptr_o(actp[1]), .ptr_pending_o(pnd[1])
    );

    // Reference model: byte lanes per word, validity flags, pointer registers.
    logic [7:0]  m_hi [2][1024];
    logic [7:0]  m_lo [2][1024];
    bit          v_hi [2][1024];
    bit          v_lo [2][1024];
    logic [7:0]  m_sh [2];
    logic [15:0] m_pend [2];
    logic [15:0] m_act [2];
    bit          m_pnd [2];

    task automatic model_reset();
        for (int d = 0; d < 2; d++) begin
            m_sh[d] = 8'h00; m_pend[d] = FB; m_act[d] = FB; m_pnd[d] = 1'b0;
        end
    endtask

    task automatic model_write(input int d, input logic [15:0] a, input logic [7:0] v, input logic s);
        int o;
        if (s) begin
            if (int'(a) >= int'(FB) && int'(a) < int'(FB) + 2048) begin
                o = int'(a) - int'(FB);
                if (o % 2 == 0) begin m_hi[d][o/2] = v; v_hi[d][o/2] = 1'b1; end
                else            begin m_lo[d][o/2] = v; v_lo[d][o/2] = 1'b1; end
            end else if (int'(a) >= int'(RG) && int'(a) < int'(RG) + 4) begin
                o = int'(a) - int'(RG);
                if (o == 0) m_sh[d] = v;
                else if (o == 1) begin m_pend[d] = {m_sh[d], v}; m_pnd[d] = 1'b1; end
            end
        end
    endtask

    task automatic model_read(input int d, input logic [15:0] a, output logic [7:0] e, output bit known);
        int o;
        e = 8'h00; known = 1'b1;
        if (int'(a) >= int'(FB) && int'(a) < int'(FB) + 2048) begin
            o = int'(a) - int'(FB);
            if (o % 2 == 0) begin e = m_hi[d][o/2]; known = v_hi[d][o/2]; end
            else            begin e = m_lo[d][o/2]; known = v_lo[d][o/2]; end
        end else if (int'(a) >= int'(RG) && int'(a) < int'(RG) + 4) begin
            o = int'(a) - int'(RG);
            case (o)
                0: e = m_sh[d];
                1: e = m_pend[d][7:0];
                2: e = {6'b0, m_act[d][10], m_pnd[d]};
                default: e = 8'h00;
            endcase
        end
    endtask

    task automatic model_sync();
        for (int d = 0; d < 2; d++) begin
            if (m_pnd[d]) begin m_act[d] = m_pend[d]; m_pnd[d] = 1'b0; end
        end
    endtask

    // One bus beat; lat counts rising edges from the strobe until ack is seen.
    task automatic bus_xfer(input int d, input logic [15:0] a, input logic w, input logic [7:0] v,
                            input logic s, output bit acked, output logic [7:0] rd, output int lat,
                            output logic ack_after, output logic [15:0] pix_after);
        acked = 1'b0; rd = 8'h00; lat = 0;
        @(posedge clk); #1;
        adr = a; we = w; dat = v; sel = s; cyc[d] = 1'b1; stb[d] = 1'b1;
        for (int i = 1; i <= BUDGET; i++) begin
            @(posedge clk); @(negedge clk);
            rd = dato[d];
            if (ack[d] === 1'b1) begin acked = 1'b1; lat = i; break; end
        end
        cyc[d] = 1'b0; stb[d] = 1'b0;
        @(posedge clk); @(negedge clk);
        ack_after = ack[d];
        pix_after = pixd[d];
        if (acked && w) model_write(d, a, v, s);
    endtask

    task automatic pix_read(input int d, input logic [8:0] p, output logic [15:0] val);
        @(posedge clk); #1 pix = p;
        @(posedge clk); @(negedge clk);
        val = pixd[d];
    endtask

    task automatic pulse_fs();
        @(posedge clk); #1 fs = 1'b1;
        @(posedge clk); #1 fs = 1'b0;
        model_sync();
        @(negedge clk);
    endtask

    task automatic test_reset();
        rst_n = 1'b0;
        repeat (2) @(posedge clk);
        @(negedge clk);
        for (int d = 0; d < 2; d++) begin
            total++; if (ack[d] !== 1'b0)    begin bad++; $display("FAIL reset_ack[%0d]: got %b exp 0", d, ack[d]); end
            total++; if (dato[d] !== 8'h00)  begin bad++; $display("FAIL reset_dat[%0d]: got %h exp 00", d, dato[d]); end
            total++; if (pixd[d] !== 16'h0)  begin bad++; $display("FAIL reset_pix[%0d]: got %h exp 0000", d, pixd[d]); end
            total++; if (actp[d] !== FB)     begin bad++; $display("FAIL reset_ptr[%0d]: got %h exp %h", d, actp[d], FB); end
            total++; if (pnd[d] !== 1'b0)    begin bad++; $display("FAIL reset_pend[%0d]: got %b exp 0", d, pnd[d]); end
        end
        rst_n = 1'b1;
        model_reset();
    endtask

    task automatic test_fb_write();
        bit ok; logic [7:0] rd; int lat; logic aa; logic [15:0] pa, pv;
        bus_xfer(0, FB + 16'd0, 1'b1, 8'hF8, 1'b1, ok, rd, lat, aa, pa);
        total++; if (!ok || lat != 1) begin bad++; $display("FAIL wr0_latency: got ack=%0d lat=%0d exp ack=1 lat=1", ok, lat); end
        total++; if (aa !== 1'b0)     begin bad++; $display("FAIL wr0_ack_width: got %b exp 0", aa); end
        bus_xfer(0, FB + 16'd1, 1'b1, 8'h00, 1'b1, ok, rd, lat, aa, pa);
        total++; if (!ok || lat != 1) begin bad++; $display("FAIL wr1_latency: got ack=%0d lat=%0d exp ack=1 lat=1", ok, lat); end
        total++; if (aa !== 1'b0)     begin bad++; $display("FAIL wr1_ack_width: got %b exp 0", aa); end
        pix_read(0, 9'd0, pv);
        total++; if (pv !== 16'hF800) begin bad++; $display("FAIL pix_word0: got %h exp F800", pv); end
    endtask

    task automatic test_ptr_flip();
        bit ok; logic [7:0] rd; int lat; logic aa; logic [15:0] pa;
        bus_xfer(0, RG + 16'd0, 1'b1, 8'h04, 1'b1, ok, rd, lat, aa, pa);
        bus_xfer(0, RG + 16'd1, 1'b1, 8'h00, 1'b1, ok, rd, lat, aa, pa);
        total++; if (pnd[0] !== 1'b1) begin bad++; $display("FAIL commit_pending: got %b exp 1", pnd[0]); end
        total++; if (actp[0] !== FB)  begin bad++; $display("FAIL commit_active: got %h exp %h", actp[0], FB); end
        pulse_fs();
        total++; if (actp[0] !== 16'h0400) begin bad++; $display("FAIL flip_active: got %h exp 0400", actp[0]); end
        total++; if (pnd[0] !== 1'b0)      begin bad++; $display("FAIL flip_pending: got %b exp 0", pnd[0]); end
        bus_xfer(0, RG + 16'd2, 1'b0, 8'h00, 1'b1, ok, rd, lat, aa, pa);
        total++; if (!ok || rd !== 8'h02) begin bad++; $display("FAIL status_rd: got ack=%0d %h exp ack=1 02", ok, rd); end
        bus_xfer(0, RG + 16'd0, 1'b0, 8'h00, 1'b1, ok, rd, lat, aa, pa);
        total++; if (!ok || rd !== 8'h04) begin bad++; $display("FAIL shadow_rd: got ack=%0d %h exp ack=1 04", ok, rd); end
        bus_xfer(0, RG + 16'd3, 1'b1, 8'hFF, 1'b1, ok, rd, lat, aa, pa);
        bus_xfer(0, RG + 16'd3, 1'b0, 8'h00, 1'b1, ok, rd, lat, aa, pa);
        total++; if (!ok || rd !== 8'h00) begin bad++; $display("FAIL reg3_rd: got ack=%0d %h exp ack=1 00", ok, rd); end
    endtask

    task automatic test_wrap();
        bit ok; logic [7:0] rd, r1, r2, nh; int lat; logic aa; logic [15:0] pa, pv, old;
        r1 = 8'($urandom); r2 = 8'($urandom);
        bus_xfer(0, FB + 16'd2046, 1'b1, r1, 1'b1, ok, rd, lat, aa, pa);
        bus_xfer(0, FB + 16'd2047, 1'b1, r2, 1'b1, ok, rd, lat, aa, pa);
        pix_read(0, 9'd511, pv);
        total++; if (pv !== {r1, r2}) begin bad++; $display("FAIL pix_word1023: got %h exp %h", pv, {r1, r2}); end
        // Pointer 0x0402 -> base word 513; pixel 511 wraps to word 0.
        bus_xfer(0, RG + 16'd0, 1'b1, 8'h04, 1'b1, ok, rd, lat, aa, pa);
        bus_xfer(0, RG + 16'd1, 1'b1, 8'h02, 1'b1, ok, rd, lat, aa, pa);
        pulse_fs();
        pix_read(0, 9'd511, pv);
        total++; if (pv !== {m_hi[0][0], m_lo[0][0]}) begin bad++; $display("FAIL pix_wrap: got %h exp %h", pv, {m_hi[0][0], m_lo[0][0]}); end
        // Read-first: pixel port sits on word 513 while its high byte is rewritten.
        bus_xfer(0, FB + 16'd1026, 1'b1, 8'h12, 1'b1, ok, rd, lat, aa, pa);
        bus_xfer(0, FB + 16'd1027, 1'b1, 8'h34, 1'b1, ok, rd, lat, aa, pa);
        pix_read(0, 9'd0, pv);
        old = {m_hi[0][513], m_lo[0][513]};
        nh  = 8'($urandom) | 8'h01;
        bus_xfer(0, FB + 16'd1026, 1'b1, nh, 1'b1, ok, rd, lat, aa, pa);
        total++; if (pa !== old) begin bad++; $display("FAIL read_first: got %h exp %h", pa, old); end
        @(posedge clk); @(negedge clk);
        total++; if (pixd[0] !== {nh, 8'h34}) begin bad++; $display("FAIL read_after_write: got %h exp %h", pixd[0], {nh, 8'h34}); end
    endtask

    task automatic test_wait_states();
        bit ok, seen; logic [7:0] rd, e; int lat; logic aa; logic [15:0] pa; bit kn;
        bus_xfer(1, FB + 16'd1, 1'b1, 8'h00, 1'b1, ok, rd, lat, aa, pa);
        total++; if (!ok || lat != 4) begin bad++; $display("FAIL ws3_wr_latency: got ack=%0d lat=%0d exp ack=1 lat=4", ok, lat); end
        bus_xfer(1, FB + 16'd1, 1'b0, 8'h00, 1'b1, ok, rd, lat, aa, pa);
        total++; if (!ok || lat != 4 || rd !== 8'h00) begin bad++; $display("FAIL ws3_rd: got ack=%0d lat=%0d %h exp ack=1 lat=4 00", ok, lat, rd); end
        total++; if (aa !== 1'b0) begin bad++; $display("FAIL ws3_ack_width: got %b exp 0", aa); end
        @(posedge clk); #1;
        adr = FB + 16'd1; we = 1'b1; dat = 8'hAA; sel = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
        seen = 1'b0;
        repeat (2) begin @(posedge clk); @(negedge clk); if (ack[1] === 1'b1) seen = 1'b1; end
        stb[1] = 1'b0; cyc[1] = 1'b0;
        repeat (6) begin @(posedge clk); @(negedge clk); if (ack[1] === 1'b1) seen = 1'b1; end
        total++; if (seen) begin bad++; $display("FAIL ws3_abort_ack: got ack seen exp none"); end
        bus_xfer(1, FB + 16'd1, 1'b0, 8'h00, 1'b1, ok, rd, lat, aa, pa);
        model_read(1, FB + 16'd1, e, kn);
        total++; if (!ok || rd !== e) begin bad++; $display("FAIL ws3_abort_nowrite: got ack=%0d %h exp ack=1 %h", ok, rd, e); end
    endtask

    task automatic test_unmapped();
        bit ok; logic [7:0] rd; int lat; logic aa; logic [15:0] pa;
        logic [15:0] addrs [3];
        addrs[0] = 16'h2000; addrs[1] = FB + 16'd2048; addrs[2] = RG + 16'd4;
        for (int k = 0; k < 3; k++) begin
            bus_xfer(0, addrs[k], 1'b0, 8'h00, 1'b1, ok, rd, lat, aa, pa);
            total++; if (ok || rd !== 8'h00) begin bad++; $display("FAIL unmapped_%h: got ack=%0d %h exp ack=0 00", addrs[k], ok, rd); end
        end
    endtask

    task automatic test_sync_commit();
        bit ok; logic [7:0] rd; int lat; logic aa; logic [15:0] pa, prev;
        total++; if (pnd[0] !== 1'b0) begin bad++; $display("FAIL pre_sync_pending: got %b exp 0", pnd[0]); end
        prev = m_act[0];
        bus_xfer(0, RG + 16'd0, 1'b1, 8'h00, 1'b1, ok, rd, lat, aa, pa);
        @(posedge clk); #1;
        adr = RG + 16'd1; we = 1'b1; dat = 8'h08; sel = 1'b1; cyc[0] = 1'b1; stb[0] = 1'b1;
        @(posedge clk); #1 fs = 1'b1;
        @(negedge clk);
        total++; if (ack[0] !== 1'b1) begin bad++; $display("FAIL sync_commit_ack: got %b exp 1", ack[0]); end
        cyc[0] = 1'b0; stb[0] = 1'b0;
        model_sync();
        model_write(0, RG + 16'd1, 8'h08, 1'b1);
        @(posedge clk); #1 fs = 1'b0;
        @(negedge clk);
        total++; if (actp[0] !== prev)  begin bad++; $display("FAIL sync_commit_active: got %h exp %h", actp[0], prev); end
        total++; if (pnd[0] !== 1'b1)   begin bad++; $display("FAIL sync_commit_pending: got %b exp 1", pnd[0]); end
        pulse_fs();
        total++; if (actp[0] !== 16'h0008) begin bad++; $display("FAIL next_sync_active: got %h exp 0008", actp[0]); end
        // Two commits before a sync: only the last one lands.
        bus_xfer(0, RG + 16'd0, 1'b1, 8'h04, 1'b1, ok, rd, lat, aa, pa);
        bus_xfer(0, RG + 16'd1, 1'b1, 8'h00, 1'b1, ok, rd, lat, aa, pa);
        bus_xfer(0, RG + 16'd1, 1'b1, 8'h06, 1'b1, ok, rd, lat, aa, pa);
        pulse_fs();
        total++; if (actp[0] !== 16'h0406) begin bad++; $display("FAIL overwrite_commit: got %h exp 0406", actp[0]); end
    endtask

    task automatic test_random();
        bit ok, kn; logic [7:0] rd, e, vh, vl; int lat, w, p, base, ww; logic aa; logic [15:0] pa, pv, ptr;
        logic [15:0] ba;
        for (int it = 0; it < 12; it++) begin
            w  = $urandom_range(0, 1023);
            vh = 8'($urandom); vl = 8'($urandom);
            bus_xfer(0, FB + 16'(2 * w), 1'b1, vh, 1'b1, ok, rd, lat, aa, pa);
            bus_xfer(0, FB + 16'(2 * w + 1), 1'b1, vl, 1'b1, ok, rd, lat, aa, pa);
            ba = FB + 16'(2 * w + $urandom_range(0, 1));
            bus_xfer(0, ba, 1'b1, ~8'($urandom), 1'b0, ok, rd, lat, aa, pa);
            total++; if (!ok) begin bad++; $display("FAIL rnd_sel0_ack[%0d]: got 0 exp 1", it); end
            bus_xfer(0, ba, 1'b0, 8'h00, 1'b1, ok, rd, lat, aa, pa);
            model_read(0, ba, e, kn);
            total++; if (!ok || rd !== e) begin bad++; $display("FAIL rnd_bus_rd[%0d]: got ack=%0d %h exp ack=1 %h", it, ok, rd, e); end
            p    = $urandom_range(0, 511);
            base = (w - p + 1024) % 1024;
            ptr  = 16'(int'(FB) + 2 * base + $urandom_range(0, 1));
            bus_xfer(0, RG + 16'd0, 1'b1, ptr[15:8], 1'b1, ok, rd, lat, aa, pa);
            bus_xfer(0, RG + 16'd1, 1'b1, ptr[7:0], 1'b1, ok, rd, lat, aa, pa);
            pulse_fs();
            total++; if (actp[0] !== m_act[0]) begin bad++; $display("FAIL rnd_ptr[%0d]: got %h exp %h", it, actp[0], m_act[0]); end
            pix_read(0, 9'(p), pv);
            ww = ((int'(m_act[0]) - int'(FB)) / 2 + p) % 1024;
            total++; if (pv !== {m_hi[0][ww], m_lo[0][ww]}) begin bad++; $display("FAIL rnd_pix[%0d]: got %h exp %h", it, pv, {m_hi[0][ww], m_lo[0][ww]}); end
        end
    endtask

    task automatic test_reset_mid_wait();
        bit ok, kn; logic [7:0] rd, e; int lat; logic aa; logic [15:0] pa, pv;
        bus_xfer(1, RG + 16'd0, 1'b1, 8'h04, 1'b1, ok, rd, lat, aa, pa);
        bus_xfer(1, RG + 16'd1, 1'b1, 8'h00, 1'b1, ok, rd, lat, aa, pa);
        pulse_fs();
        total++; if (actp[1] !== 16'h0400) begin bad++; $display("FAIL ws3_flip: got %h exp 0400", actp[1]); end
        @(posedge clk); #1;
        adr = FB + 16'd1; we = 1'b1; dat = 8'h5A; sel = 1'b1; cyc[1] = 1'b1; stb[1] = 1'b1;
        @(posedge clk); @(posedge clk); @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk); @(negedge clk);
        total++; if (ack[1] !== 1'b0)  begin bad++; $display("FAIL midwait_ack: got %b exp 0", ack[1]); end
        total++; if (actp[1] !== FB)   begin bad++; $display("FAIL midwait_ptr: got %h exp %h", actp[1], FB); end
        total++; if (pnd[1] !== 1'b0)  begin bad++; $display("FAIL midwait_pend: got %b exp 0", pnd[1]); end
        cyc[1] = 1'b0; stb[1] = 1'b0;
        rst_n = 1'b1;
        model_reset();
        bus_xfer(1, FB + 16'd1, 1'b0, 8'h00, 1'b1, ok, rd, lat, aa, pa);
        model_read(1, FB + 16'd1, e, kn);
        total++; if (!ok || rd !== e) begin bad++; $display("FAIL midwait_retain: got ack=%0d %h exp ack=1 %h", ok, rd, e); end
        pix_read(0, 9'd0, pv);
        total++; if (pv !== {m_hi[0][0], m_lo[0][0]}) begin bad++; $display("FAIL reset_ram_kept: got %h exp %h", pv, {m_hi[0][0], m_lo[0][0]}); end
    endtask

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not finish in time");
        $fatal(1, "watchdog");
    end

    initial begin
        rst_n = 1'b0; adr = 16'h0; dat = 8'h0; we = 1'b0; sel = 1'b0; fs = 1'b0;
        cti = 3'b000; pix = 9'd0;
        cyc[0] = 1'b0; cyc[1] = 1'b0; stb[0] = 1'b0; stb[1] = 1'b0;
        test_reset();
        test_fb_write();
        test_ptr_flip();
        test_wrap();
        test_wait_states();
        test_unmapped();
        test_sync_commit();
        test_random();
        test_reset_mid_wait();
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule

// File: doc/matrix_fb_responder.md
# matrix_fb_responder

Wishbone classic-cycle responder that terminates the pixel and frame-pointer writes issued by the pattern generators on the shared 8-bit bus. It holds a 2-page RGB565 framebuffer (2 × 512 pixels, 16 rows × 32 columns), plus the frame-pointer register that selects which page is displayed. It also provides a synchronous 16-bit pixel read port for the LED matrix scanner. A new frame pointer is double-buffered and takes effect only at the scanner's frame boundary, so a page flip never tears.

## Interface
- ADDRESS_WIDTH, 16, Wishbone address width
- DATA_WIDTH, 8, Wishbone data width; only 8 is supported
- DATA_BYTES, 1, number of select lines
- FB_BASE, 16'h0000, byte base of the 2048-byte framebuffer window
- REG_BASE, 16'h1000, byte base of the 4-byte register window
- WAIT_STATES, 0, extra cycles inserted before ack_o (0..15)

- clk_i  in  1  single clock; all logic is on the rising edge
- rst_i  in  1  reset, synchronous, active-low
- adr_i  in  ADDRESS_WIDTH  byte address
- dat_i  in  DATA_WIDTH  write data
- dat_o  out  DATA_WIDTH  read data; valid while ack_o=1, 0 otherwise
- we_i  in  1  write enable
- sel_i  in  DATA_BYTES  byte select; a write with sel_i[0]=0 is acked but not stored
- stb_i  in  1  strobe
- cyc_i  in  1  bus cycle
- ack_o  out  1  single-cycle acknowledge
- cti_i  in  3  cycle type; accepted and ignored, every beat is handled as classic
- pix_addr_i  in  9  pixel index {row[3:0], col[4:0]}, relative to the active page
- pix_data_o  out  16  RGB565 data for pix_addr_i, registered with 1-cycle latency
- frame_sync_i  in  1  one-cycle pulse from the scanner at frame start
- active_ptr_o  out  16  frame pointer currently used by the pixel port
- ptr_pending_o  out  1  a committed pointer is waiting for frame_sync_i

## Operation
- Address decode:
  - FB hit when FB_BASE ≤ adr_i < FB_BASE+2048.
  - REG hit when REG_BASE ≤ adr_i < REG_BASE+4.
  - Any other address is never acked, so the master times out; dat_o stays 0.
- Framebuffer: byte offset o = adr_i − FB_BASE, word = o[10:1]. The two byte lanes are independent RAMs of 1024×8.
  - o[0]=0 addresses bits 15:8; o[0]=1 addresses bits 7:0 (big-endian, high byte first).
- Registers (offset from REG_BASE):
  - 0: pointer high byte, R/W shadow.
  - 1: pointer low byte, R/W. A write here commits {shadow_hi, dat_i} to the pending pointer and sets ptr_pending_o.
  - 2: status, read-only: {6'b0, active_ptr_o[10], ptr_pending_o}.
  - 3: reads 0.
  - Writes to offsets 2 and 3 are acked and ignored.
- Bus FSM:
  - IDLE: when cyc_i & stb_i & hit, load wait counter with WAIT_STATES and go to WAIT; if WAIT_STATES=0, go straight to ACK.
  - WAIT: decrement the counter; at 0 go to ACK. If cyc_i or stb_i drops, abort to IDLE with no side effect.
  - ACK: ack_o=1 for exactly one cycle. The write strobe fires in this cycle; read data is driven on dat_o. Then go to IDLE unconditionally.
- Frame flip:
  - On frame_sync_i with ptr_pending_o=1: active_ptr_o ← pending pointer, and ptr_pending_o clears.
  - With ptr_pending_o=0, frame_sync_i has no effect.
- Pixel port:
  - Word address = (active_ptr_o − FB_BASE)[10:1] + pix_addr_i, modulo 1024. Wrap-around past word 1023 returns to word 0.

## Timing
- Reset (rst_i=0 at a clock edge):
  - FSM goes to IDLE; ack_o=0, dat_o=0, pix_data_o=0.
  - active_ptr_o and the pending pointer are set to FB_BASE; shadow_hi=0; ptr_pending_o=0.
  - RAM contents are not cleared.
  - Reset in WAIT or ACK aborts the access with no write.
- Ack latency: ack_o rises WAIT_STATES+1 cycles after the first cycle in which cyc_i & stb_i & hit are sampled.
- Throughput: at most one access per WAIT_STATES+2 cycles, because ACK always returns through IDLE. A strobe still high after ack is treated as a new beat.
- Register write takes effect on the edge that ends the ACK cycle, so ptr_pending_o is visible in the next cycle.
- Simultaneous events:
  - Pointer commit and frame_sync_i in the same cycle: the sync uses the previous pending state. The new pointer stays pending until the next frame_sync_i.
  - Bus write and pixel read of the same word in the same cycle: pix_data_o returns the old data (read-first).
- A second pointer commit before frame_sync_i overwrites the pending value; only the last commit is applied.

## Test plan
- Reset, then with WAIT_STATES=0, write 8'hF8 to FB_BASE+0 and 8'h00 to FB_BASE+1 -> each ack_o is 1 cycle and rises 1 cycle after stb_i. With pix_addr_i=0, pix_data_o=16'hF800 one cycle later.
- Write 8'h04 to REG_BASE+0, then 8'h00 to REG_BASE+1 -> ptr_pending_o=1 while active_ptr_o=FB_BASE. Pulse frame_sync_i -> active_ptr_o=16'h0400 and ptr_pending_o=0. A read of REG_BASE+2 returns 8'h02.
- Set WAIT_STATES=3, read FB_BASE+1 -> ack_o rises 4 cycles after stb_i and dat_o=8'h00. Drop stb_i during WAIT on a second access -> no ack and no write.
- Access address 16'h2000 -> ack_o never asserts and dat_o stays 0.
- Issue the REG_BASE+1 commit in the same cycle as frame_sync_i -> active_ptr_o is unchanged. The next frame_sync_i applies the new pointer.
- With active pointer 16'h0400, write word 1023 (byte offsets 2046/2047) and read pix_addr_i=511 -> data at word 1023 is returned. Assert rst_i=0 mid-WAIT -> ack_o=0, active_ptr_o=FB_BASE, and RAM data is retained.
